// File: rtl/dac_scan_pkg.sv
// Shared types and default widths for the DAC threshold-scan sequencer.
package dac_scan_pkg;

  localparam int DAC_W           = 12;
  localparam int CNT_W           = 32;
  localparam int TIME_W          = 24;
  localparam int DAC_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DAC,
    SETTLE,
    GATE,
    REPORT,
    NEXT
  } state_e;

endpackage

// File: rtl/dac_scan_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level.
// The output pulse is one clk wide, 2-3 cycles after the input rises.
module sync_edge (
  input  logic clk,
  input  logic nres,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      sh_q <= 3'b000;
    end else begin
      sh_q <= sh_d;
    end
  end

  // sh_q[0] may be metastable; only the two later stages feed logic
  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/dac_scan_sequencer.sv
// Threshold-scan controller: steps a DAC code, waits for the DAC load handshake and
// settle time, counts discriminator hits in a gate and reports {code, count} per point.
module dac_scan_sequencer
  import dac_scan_pkg::*;
#(
  parameter int DAC_WIDTH   = DAC_W,
  parameter int CNT_WIDTH   = CNT_W,
  parameter int TIME_WIDTH  = TIME_W,
  parameter int DAC_TIMEOUT = DAC_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  nres,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DAC_WIDTH-1:0]  start_code,
  input  logic [DAC_WIDTH-1:0]  stop_code,
  input  logic [DAC_WIDTH-1:0]  step_size,
  input  logic [TIME_WIDTH-1:0] settle_len,
  input  logic [TIME_WIDTH-1:0] gate_len,
  output logic [DAC_WIDTH-1:0]  dac_code,
  output logic                  dac_req,
  input  logic                  dac_done,
  input  logic                  hit,
  output logic                  cnt_gate,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DAC_WIDTH-1:0]  res_code,
  output logic [CNT_WIDTH-1:0]  res_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int TMO_W = $clog2(DAC_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [DAC_WIDTH-1:0]  code_q, code_d;
  logic [DAC_WIDTH-1:0]  stop_q, stop_d;
  logic [DAC_WIDTH-1:0]  step_q, step_d;
  logic [TIME_WIDTH-1:0] settle_q, settle_d;
  logic [TIME_WIDTH-1:0] gate_q, gate_d;
  logic [TIME_WIDTH-1:0] tmr_q, tmr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  done_rise;
  logic                  hit_rise;
  logic [DAC_WIDTH:0]    sum;

  sync_edge u_sync_done (.clk(clk), .nres(nres), .async_in(dac_done), .rise(done_rise));
  sync_edge u_sync_hit  (.clk(clk), .nres(nres), .async_in(hit),      .rise(hit_rise));

  // Extra carry bit so a step past the top of the code range ends the scan, never wraps
  assign sum = {1'b0, code_q} + {1'b0, step_q};

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    stop_d   = stop_q;
    step_d   = step_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    tmr_d    = tmr_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          code_d   = start_code;
          stop_d   = stop_code;
          step_d   = (step_size == '0) ? DAC_WIDTH'(1) : step_size;
          settle_d = settle_len;
          gate_d   = (gate_len == '0) ? TIME_WIDTH'(1) : gate_len;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_DAC;
      end
      WAIT_DAC: begin
        if (done_rise) begin
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = SETTLE;
        end else if (tmo_q == TMO_W'(DAC_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0 || tmr_q == settle_q - TIME_WIDTH'(1)) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = GATE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GATE: begin
        if (hit_rise && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (tmr_q == gate_q - TIME_WIDTH'(1)) begin
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (code_q == stop_q || sum[DAC_WIDTH] || sum[DAC_WIDTH-1:0] > stop_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          code_d  = sum[DAC_WIDTH-1:0];
          state_d = LOAD;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything: the point in flight is dropped, DAC code is left as-is
    if (abort) begin
      state_d = IDLE;
      code_d  = code_q;
      req_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q  <= IDLE;
      code_q   <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      tmr_q    <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      tmr_q    <= tmr_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign dac_code    = code_q;
  assign dac_req     = req_q;
  assign cnt_gate    = (state_q == GATE);
  assign res_valid   = (state_q == REPORT);
  assign res_code    = code_q;
  assign res_count   = cnt_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Randomized self-checking bench for dac_scan_sequencer against a scan-list reference model.
module tb_dac_scan_sequencer;

  logic        clk = 1'b0;
  logic        nres = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] start_code = '0;
  logic [11:0] stop_code = '0;
  logic [11:0] step_size = '0;
  logic [23:0] settle_len = '0;
  logic [23:0] gate_len = '0;
  logic        dac_done = 1'b0;
  logic        hit = 1'b0;
  logic        res_ready = 1'b0;
  logic [11:0] dac_code;
  logic        dac_req;
  logic        cnt_gate;
  logic        res_valid;
  logic [11:0] res_code;
  logic [31:0] res_count;
  logic        busy;
  logic        done;
  logic        err_timeout;

  int n_vec = 0;
  int n_miss = 0;
  int done_seen = 0;
  int gate_seen = 0;
  int req_in_report = 0;
  int valid_seen = 0;
  logic [11:0] exp_q[$];

  dac_scan_sequencer #(
    .DAC_WIDTH(12), .CNT_WIDTH(32), .TIME_WIDTH(24), .DAC_TIMEOUT(64)
  ) dut (
    .clk(clk), .nres(nres), .start(start), .abort(abort),
    .start_code(start_code), .stop_code(stop_code), .step_size(step_size),
    .settle_len(settle_len), .gate_len(gate_len),
    .dac_code(dac_code), .dac_req(dac_req), .dac_done(dac_done), .hit(hit),
    .cnt_gate(cnt_gate), .res_valid(res_valid), .res_ready(res_ready),
    .res_code(res_code), .res_count(res_count), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All time advances here; observations are taken on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (cnt_gate) gate_seen++;
    if (done) done_seen++;
    if (res_valid) valid_seen++;
    if (res_valid && dac_req) req_in_report++;
  endtask

  task automatic pulse_hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; tick(); tick();
      hit = 1'b0; tick();
    end
  endtask

  // Expected scan points straight from the stepping rules, in plain integer arithmetic.
  function automatic void build_points(input int s, input int p, input int st);
    int stp;
    int c;
    stp = (st == 0) ? 1 : st;
    c = s;
    exp_q.delete();
    while (1) begin
      exp_q.push_back(c[11:0]);
      if (c == p || c + stp > p) break;
      c += stp;
    end
  endfunction

  task automatic pulse_start(input int s, input int p, input int st, input int settle, input int gate);
    start_code = s[11:0];
    stop_code  = p[11:0];
    step_size  = st[11:0];
    settle_len = settle[23:0];
    gate_len   = gate[23:0];
    start = 1'b1; tick(); start = 1'b0;
    // Inputs are only sampled on acceptance, so scramble them afterwards
    start_code = 12'($urandom);
    stop_code  = 12'($urandom);
    step_size  = 12'($urandom);
    settle_len = 24'($urandom_range(0, 40));
    gate_len   = 24'($urandom_range(0, 40));
  endtask

  task automatic run_scan(input int s, input int p, input int st, input int settle, input int gate,
                          input int dac_dly, input int rdy_dly, input int k_force);
    int gate_eff;
    int pre;
    int k;
    int bound;
    logic [11:0] c0;
    logic [31:0] n0;
    bit stable;
    gate_eff = (gate == 0) ? 1 : gate;
    build_points(s, p, st);
    done_seen = 0;
    req_in_report = 0;
    pulse_start(s, p, st, settle, gate);
    check_eq("err_clear_on_start", err_timeout, 0);
    check_eq("busy_after_start", busy, 1);
    foreach (exp_q[i]) begin
      bound = 0;
      while (!dac_req && bound < 50) begin tick(); bound++; end
      check_eq("dac_req_raised", dac_req, 1);
      check_eq("dac_code", dac_code, exp_q[i]);
      if (i == 0) begin
        start = 1'b1; tick(); start = 1'b0;
      end
      repeat (dac_dly) tick();
      dac_done = 1'b1; tick(); tick(); dac_done = 1'b0;
      pre = (settle >= 7) ? (((settle - 4) / 3 > 2) ? 2 : (settle - 4) / 3) : 0;
      gate_seen = 0;
      pulse_hits(pre);
      bound = 0;
      while (gate_seen == 0 && bound < 300) begin tick(); bound++; end
      if (k_force >= 0) k = k_force;
      else k = (gate_eff >= 6) ? $urandom_range(0, (gate_eff - 3) / 3) : 0;
      pulse_hits(k);
      bound = 0;
      while (cnt_gate && bound < 300) begin tick(); bound++; end
      check_eq("gate_cycles", gate_seen, gate_eff);
      pulse_hits($urandom_range(0, 2));
      repeat (3) tick();
      check_eq("res_valid", res_valid, 1);
      c0 = res_code;
      n0 = res_count;
      stable = 1'b1;
      repeat (rdy_dly) begin
        tick();
        if (!res_valid || res_code !== c0 || res_count !== n0) stable = 1'b0;
      end
      check_eq("res_stable", stable, 1);
      check_eq("res_code", res_code, exp_q[i]);
      check_eq("res_count", res_count, k);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
    end
    bound = 0;
    while (busy && bound < 20) begin tick(); bound++; end
    repeat (2) tick();
    check_eq("done_pulses", done_seen, 1);
    check_eq("busy_at_end", busy, 0);
    check_eq("req_during_report", req_in_report, 0);
  endtask

  initial begin
    int elapsed;
    int bound;
    int s;
    int p;
    repeat (3) tick();
    check_eq("reset_outputs",
             {dac_code, dac_req, cnt_gate, res_valid, res_code, res_count, busy, done, err_timeout}, 0);
    nres = 1'b1;
    repeat (2) tick();

    run_scan(12'h100, 12'h104, 2, 4, 10, 5, 0, -1);
    run_scan(12'h040, 12'h040, 1, 20, 24, 3, 2, 7);
    run_scan(12'h010, 12'h012, 0, 2, 0, 4, 50, -1);

    // DAC never answers
    done_seen = 0;
    pulse_start(12'h080, 12'h090, 1, 3, 5);
    bound = 0;
    while (!dac_req && bound < 20) begin tick(); bound++; end
    elapsed = 0;
    while (!err_timeout && elapsed < 200) begin tick(); elapsed++; end
    check_eq("timeout_cycles", elapsed, 64);
    check_eq("timeout_req_dropped", dac_req, 0);
    check_eq("timeout_idle", busy, 0);
    repeat (5) tick();
    check_eq("timeout_sticky", err_timeout, 1);
    check_eq("timeout_no_done", done_seen, 0);
    run_scan(12'h0A0, 12'h0A2, 1, 1, 3, 2, 1, -1);

    run_scan(12'hFFE, 12'hFFF, 4, 3, 8, 2, 1, -1);
    run_scan(12'h200, 12'h100, 3, 0, 6, 1, 0, -1);
    run_scan(12'hFFD, 12'hFFF, 1, 1, 7, 6, 3, -1);

    // Abort in the middle of a gate
    done_seen = 0;
    pulse_start(12'h300, 12'h310, 4, 3, 30);
    bound = 0;
    while (!dac_req && bound < 20) begin tick(); bound++; end
    repeat (3) tick();
    dac_done = 1'b1; tick(); tick(); dac_done = 1'b0;
    gate_seen = 0;
    bound = 0;
    while (gate_seen == 0 && bound < 100) begin tick(); bound++; end
    repeat (3) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_gate_low", cnt_gate, 0);
    check_eq("abort_idle", busy, 0);
    check_eq("abort_req_low", dac_req, 0);
    check_eq("abort_code_kept", dac_code, 12'h300);
    valid_seen = 0;
    repeat (20) tick();
    check_eq("abort_no_result", valid_seen, 0);
    check_eq("abort_no_done", done_seen, 0);

    // Abort wins over a simultaneous start
    start_code = 12'h123; stop_code = 12'h124; step_size = 12'h1;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    check_eq("abort_beats_start", busy, 0);

    // Reset while waiting on the DAC
    pulse_start(12'h456, 12'h460, 2, 1, 4);
    bound = 0;
    while (!dac_req && bound < 20) begin tick(); bound++; end
    tick();
    nres = 1'b0;
    #1;
    check_eq("reset_mid_scan", {dac_req, cnt_gate, res_valid, busy, dac_code}, 0);
    tick(); tick();
    nres = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 4095);
      p = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4095) : s + $urandom_range(0, 20);
      if (p > 4095) p = 4095;
      run_scan(s, p, $urandom_range(0, 7), $urandom_range(0, 16), $urandom_range(0, 20),
               $urandom_range(1, 8), $urandom_range(0, 6), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
